// File: rtl/ctrl_paso_cpu_pkg.sv
// ctrl_paso_cpu_pkg: state encoding and display width shared with the LED/7-segment block
package ctrl_paso_cpu_pkg;
    localparam int ESTADO_W = 2;
    typedef enum logic [ESTADO_W-1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } estado_t;
endpackage

// File: rtl/ctrl_paso_cpu_if.sv
// ctrl_paso_cpu_if: button/mode/halt inputs and enable/count/state outputs of the step controller
//   master: drives pulso, modo, halt; observes en_cpu, cuenta, estado, ocupado
//   slave : the controller side
interface ctrl_paso_cpu_if
    import ctrl_paso_cpu_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic                pulso;
    logic                modo;
    logic                halt;
    logic                en_cpu;
    logic [CNT_W-1:0]    cuenta;
    logic [ESTADO_W-1:0] estado;
    logic                ocupado;
    modport master(output pulso, modo, halt, input en_cpu, cuenta, estado, ocupado);
    modport slave(input pulso, modo, halt, output en_cpu, cuenta, estado, ocupado);
endinterface

// File: rtl/ctrl_paso_cpu_div.sv
// div_habilitador: run-mode prescaler, one-cycle tick every PRESC_DIV cycles while not cleared
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (held while not running)
//   tick     : high in the cycle the count sits at PRESC_DIV-1
module div_habilitador #(
    parameter int PRESC_DIV = 1000000,
    parameter int PRESC_W   = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    logic [PRESC_W-1:0] cnt;
    assign tick = ~clr & (cnt == PRESC_W'(PRESC_DIV - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= (clr | tick) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/ctrl_paso_cpu.sv
// ctrl_paso_cpu: turns button pulses into single-step or prescaled-run CPU clock enables
//   clk, rst : clock, async active-high reset
//   bus      : slave side of ctrl_paso_cpu_if (pulso/modo/halt in; en_cpu/cuenta/estado/ocupado out)
module ctrl_paso_cpu
    import ctrl_paso_cpu_pkg::*;
#(
    parameter int PRESC_DIV = 1000000,
    parameter int PRESC_W   = 20,
    parameter int CNT_W     = 16
) (
    input logic           clk,
    input logic           rst,
    ctrl_paso_cpu_if.slave bus
);
    estado_t          state, nxt;
    logic             pulso_q, pedge, tick, en, en_d;
    logic [CNT_W-1:0] cuenta;
    assign pedge       = bus.pulso & ~pulso_q;
    assign bus.en_cpu  = en;
    assign bus.cuenta  = cuenta;
    assign bus.estado  = state;
    assign bus.ocupado = (state == RUN);
    // prescaler is held at zero outside RUN, so entering RUN always starts a fresh period
    div_habilitador #(.PRESC_DIV(PRESC_DIV), .PRESC_W(PRESC_W)) u_div (
        .clk (clk),
        .rst (rst),
        .clr (state != RUN),
        .tick(tick)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pulso_q <= 1'b0;
            en      <= 1'b0;
            cuenta  <= '0;
        end else begin
            state   <= nxt;
            pulso_q <= bus.pulso;
            en      <= en_d;
            cuenta  <= cuenta + CNT_W'(en);
        end
    end
    // halt always takes priority over a button edge
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.halt ? HALTED : pedge ? (bus.modo ? RUN : STEP) : IDLE;
            STEP:    nxt = bus.halt ? HALTED : IDLE;
            RUN:     nxt = bus.halt ? HALTED : (pedge | ~bus.modo) ? IDLE : RUN;
            HALTED:  nxt = (pedge & ~bus.halt) ? IDLE : HALTED;
            default: nxt = IDLE;
        endcase
        // a tick in the cycle RUN is left is dropped
        en_d = (nxt == STEP) | (nxt == RUN & tick);
    end
endmodule

// File: tb/tb_ctrl_paso_cpu.sv
// tb_ctrl_paso_cpu: directed checks of step, run, halt, wrap and async reset behaviour
module tb_ctrl_paso_cpu;
    import ctrl_paso_cpu_pkg::*;
    logic clk, rst;
    int   vectors = 0;
    int   errs    = 0;
    int   ens;
    ctrl_paso_cpu_if #(.CNT_W(4)) bus ();
    ctrl_paso_cpu #(.PRESC_DIV(4), .PRESC_W(3), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
        ens += int'(bus.en_cpu);
    endtask
    task automatic outs(input string tag, input logic en, input logic [3:0] cu, input logic [1:0] st);
        chk({tag, ".en"}, 32'(bus.en_cpu), 32'(en));
        chk({tag, ".cuenta"}, 32'(bus.cuenta), 32'(cu));
        chk({tag, ".estado"}, 32'(bus.estado), 32'(st));
        chk({tag, ".ocupado"}, 32'(bus.ocupado), 32'(st == 2'd2));
    endtask
    initial begin
        rst = 1'b1;
        bus.pulso = 1'b0;
        bus.modo  = 1'b0;
        bus.halt  = 1'b0;
        #7;
        outs("reset", 1'b0, 4'd0, 2'd0);
        #5 rst = 1'b0;
        cyc();
        // 1: step press held high for 100 cycles yields a single enable
        bus.pulso = 1'b1;
        ens = 0;
        cyc();
        outs("step_first", 1'b1, 4'd0, 2'd1);
        repeat (99) cyc();
        chk("step_en_count", 32'(ens), 32'd1);
        outs("step_end", 1'b0, 4'd1, 2'd0);
        bus.pulso = 1'b0;
        cyc();
        // 2: run mode, enables every 4 cycles, second press stops it
        bus.modo  = 1'b1;
        bus.pulso = 1'b1;
        cyc();
        outs("run_entry", 1'b0, 4'd1, 2'd2);
        bus.pulso = 1'b0;
        ens = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            chk($sformatf("run_en_c%0d", k), 32'(bus.en_cpu), 32'(k % 4 == 0));
        end
        chk("run_en_count", 32'(ens), 32'd5);
        bus.pulso = 1'b1;
        cyc();
        outs("run_stop", 1'b0, 4'd6, 2'd0);
        bus.pulso = 1'b0;
        ens = 0;
        repeat (8) cyc();
        chk("run_stop_quiet", 32'(ens), 32'd0);
        // 3: halt in run suppresses the enable that was due
        bus.pulso = 1'b1;
        cyc();
        bus.pulso = 1'b0;
        repeat (7) cyc();
        outs("run2_c7", 1'b0, 4'd7, 2'd2);
        bus.halt = 1'b1;
        ens = 0;
        cyc();
        outs("halt_enter", 1'b0, 4'd7, 2'd3);
        repeat (5) cyc();
        chk("halt_quiet", 32'(ens), 32'd0);
        bus.pulso = 1'b1;
        cyc();
        chk("halt_press_ignored", 32'(bus.estado), 32'd3);
        bus.pulso = 1'b0;
        cyc();
        bus.halt = 1'b0;
        cyc();
        chk("halt_drop_no_press", 32'(bus.estado), 32'd3);
        bus.pulso = 1'b1;
        cyc();
        outs("halt_exit", 1'b0, 4'd7, 2'd0);
        bus.pulso = 1'b0;
        cyc();
        // 4: pedge with halt in idle, then modo drop in run
        bus.modo  = 1'b0;
        bus.halt  = 1'b1;
        bus.pulso = 1'b1;
        ens = 0;
        cyc();
        outs("idle_halt_pedge", 1'b0, 4'd7, 2'd3);
        bus.halt  = 1'b0;
        bus.pulso = 1'b0;
        cyc();
        bus.pulso = 1'b1;
        cyc();
        chk("idle_halt_release", 32'(bus.estado), 32'd0);
        bus.pulso = 1'b0;
        cyc();
        chk("idle_halt_no_en", 32'(ens), 32'd0);
        bus.modo  = 1'b1;
        bus.pulso = 1'b1;
        cyc();
        bus.pulso = 1'b0;
        repeat (3) cyc();
        bus.modo = 1'b0;
        cyc();
        outs("modo_drop", 1'b0, 4'd7, 2'd0);
        cyc();
        chk("modo_drop_quiet", 32'(ens), 32'd0);
        // 5: counter wraps modulo 16
        for (int p = 1; p <= 17; p++) begin
            bus.pulso = 1'b1;
            cyc();
            bus.pulso = 1'b0;
            cyc();
            if (p == 9) chk("wrap_zero", 32'(bus.cuenta), 32'd0);
        end
        outs("wrap_end", 1'b0, 4'd8, 2'd0);
        // 6: async reset while an enable is high in run
        bus.modo  = 1'b1;
        bus.pulso = 1'b1;
        cyc();
        bus.pulso = 1'b0;
        repeat (8) cyc();
        outs("pre_reset", 1'b1, 4'd9, 2'd2);
        #2 rst = 1'b1;
        #1;
        outs("async_reset", 1'b0, 4'd0, 2'd0);
        #1 rst = 1'b0;
        bus.modo = 1'b0;
        cyc();
        bus.pulso = 1'b1;
        cyc();
        outs("post_reset_step", 1'b1, 4'd0, 2'd1);
        cyc();
        outs("post_reset_idle", 1'b0, 4'd1, 2'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
